// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, registers the fetched instruction and PC+4 into IF/ID.
// Latency: 1 cycle fetch->ID; a redirect decided in ID fetches its target next cycle (1 bubble).
// Backpressure: stall holds PC and IF/ID together; a redirect seen during a stall is dropped and re-presented.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] IRQ_PC   = 32'h80000004,
  parameter logic [31:0] EXC_PC   = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        id_irq
);

  logic [31:0] seq_pc;
  logic [31:0] j_tgt;
  logic [31:0] br_tgt;
  logic [31:0] redirect_tgt;
  logic        redirect;
  logic        irq_pending;

  // Increment keeps the supervisor bit; the low 31 bits wrap on their own.
  assign seq_pc = {pc[31], pc[30:0] + 31'd4};
  assign j_tgt  = {id_pc_plus4[31:28], id_inst[25:0], 2'b00};
  assign br_tgt = id_pc_plus4 + {{14{id_inst[15]}}, id_inst[15:0], 2'b00};

  assign imem_addr = pc;
  // A bubble never carries the interrupt, so EPC always names a real instruction.
  assign id_irq    = irq_pending & id_valid;

  // Next-PC select: only a valid instruction in ID may redirect; undefined codes fall through to sequential.
  always_comb begin
    redirect     = 1'b0;
    redirect_tgt = seq_pc;
    if (id_valid) begin
      case (pcsrc)
        3'b000: begin redirect = 1'b1; redirect_tgt = EXC_PC;    end
        3'b001: begin redirect = 1'b1; redirect_tgt = IRQ_PC;    end
        3'b010: begin redirect = 1'b1; redirect_tgt = j_tgt;     end
        3'b011: begin redirect = 1'b1; redirect_tgt = jr_target; end
        3'b100: begin
          if (branch_taken) begin
            redirect     = 1'b1;
            redirect_tgt = br_tgt;
          end
        end
        default: begin redirect = 1'b0; redirect_tgt = seq_pc; end
      endcase
    end
  end

  // PC and IF/ID register: reset > stall > redirect (flush to bubble) > sequential fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      id_inst     <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else if (stall) begin
      pc          <= pc;
      id_inst     <= id_inst;
      id_pc_plus4 <= id_pc_plus4;
      id_valid    <= id_valid;
    end else if (redirect) begin
      pc          <= redirect_tgt;
      id_inst     <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else begin
      pc          <= seq_pc;
      id_inst     <= imem_rdata;
      id_pc_plus4 <= seq_pc;
      id_valid    <= 1'b1;
    end
  end

  // Pending-interrupt latch: set by any irq level, cleared when the IRQ redirect is actually taken (clear wins).
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_pending <= 1'b0;
    end else if (!stall && redirect && (pcsrc == 3'b001)) begin
      irq_pending <= 1'b0;
    end else if (irq) begin
      irq_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected post-edge state, a monitor pops and compares.
// Latency: each expectation is checked 1 ns after the clock edge that applies its stimulus.
// Backpressure: stall cases are covered by directed vectors.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  pcsrc;
  logic        branch_taken;
  logic [31:0] jr_target;
  logic        irq;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        id_irq;

  typedef struct {
    int          step;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] p4;
    logic        v;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pcsrc        (pcsrc),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .irq          (irq),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .id_inst      (id_inst),
    .id_pc_plus4  (id_pc_plus4),
    .id_valid     (id_valid),
    .id_irq       (id_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; unlisted addresses read as nop.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h80000000: imem = 32'h24080001;
      32'h80000004: imem = 32'h24090002;
      32'h00000100: imem = 32'h08000010;
      32'h00000040: imem = 32'h20000040;
      32'h000001FC: imem = 32'h1000FFFE;
      32'h000001F8: imem = 32'h01234567;
      32'hFFFFFFFC: imem = 32'hDEADBEEF;
      default:      imem = 32'h00000000;
    endcase
  endfunction

  assign imem_rdata = imem(imem_addr);

  task automatic chk(input int s, input string what, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h, expected %h", s, what, act, req);
    end
  endtask

  // Monitor: after every edge, compare the DUT against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.step, "pc",          pc,                 e.pc);
        chk(e.step, "imem_addr",   imem_addr,          e.pc);
        chk(e.step, "id_inst",     id_inst,            e.inst);
        chk(e.step, "id_pc_plus4", id_pc_plus4,        e.p4);
        chk(e.step, "id_valid",    {31'h0, id_valid},  {31'h0, e.v});
        chk(e.step, "id_irq",      {31'h0, id_irq},    {31'h0, e.irq});
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic rst, input logic st, input logic [2:0] ps, input logic bt,
                      input logic [31:0] jr, input logic ir,
                      input logic [31:0] e_pc, input logic [31:0] e_inst, input logic [31:0] e_p4,
                      input logic e_v, input logic e_irq);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    stall        = st;
    pcsrc        = ps;
    branch_taken = bt;
    jr_target    = jr;
    irq          = ir;
    step_no++;
    e.step = step_no;
    e.pc   = e_pc;
    e.inst = e_inst;
    e.p4   = e_p4;
    e.v    = e_v;
    e.irq  = e_irq;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; pcsrc = 3'b100; branch_taken = 1'b0; jr_target = 32'h0; irq = 1'b0;
    // Reset held two cycles, then sequential fetch from RESET_PC.
    step(0,0,3'b100,0,32'h0,0,        32'h80000000, 32'h0,        32'h0,        0,0);
    step(0,0,3'b100,0,32'h0,0,        32'h80000000, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h80000004, 32'h24080001, 32'h80000004, 1,0);
    step(1,0,3'b100,0,32'h0,0,        32'h80000008, 32'h24090002, 32'h80000008, 1,0);
    // JR to 0x100; the following bubble must ignore a JR request.
    step(1,0,3'b011,0,32'h00000100,0, 32'h00000100, 32'h0,        32'h0,        0,0);
    step(1,0,3'b011,0,32'h00000500,0, 32'h00000104, 32'h08000010, 32'h00000104, 1,0);
    // J target 0x40, flush, then the target arrives in ID.
    step(1,0,3'b010,0,32'h0,0,        32'h00000040, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h00000044, 32'h20000040, 32'h00000044, 1,0);
    // Backward branch from 0x1FC: target 0x1F8; taken flag on a bubble is ignored.
    step(1,0,3'b011,0,32'h000001FC,0, 32'h000001FC, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,1,32'h0,0,        32'h00000200, 32'h1000FFFE, 32'h00000200, 1,0);
    step(1,0,3'b100,1,32'h0,0,        32'h000001F8, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,1,32'h0,0,        32'h000001FC, 32'h01234567, 32'h000001FC, 1,0);
    // Stall beats a JR redirect; the redirect takes effect once the stall drops.
    step(1,1,3'b011,0,32'h00001000,0, 32'h000001FC, 32'h01234567, 32'h000001FC, 1,0);
    step(1,0,3'b011,0,32'h00001000,0, 32'h00001000, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h00001004, 32'h0,        32'h00001004, 1,0);
    // IRQ: pulse at pc 0x300, masked by a bubble, then the IRQ redirect clears it despite irq=1.
    step(1,0,3'b011,0,32'h00000300,0, 32'h00000300, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,1,        32'h00000304, 32'h0,        32'h00000304, 1,1);
    step(1,0,3'b011,0,32'h00000310,0, 32'h00000310, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h00000314, 32'h0,        32'h00000314, 1,1);
    step(1,0,3'b001,0,32'h0,1,        32'h80000004, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h80000008, 32'h24090002, 32'h80000008, 1,0);
    // Sequential wrap keeps bit 31 in both modes.
    step(1,0,3'b011,0,32'hFFFFFFFC,0, 32'hFFFFFFFC, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h80000000, 32'hDEADBEEF, 32'h80000000, 1,0);
    step(1,0,3'b011,0,32'h7FFFFFFC,0, 32'h7FFFFFFC, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h00000000, 32'h0,        32'h00000000, 1,0);
    // Exception redirect while an IRQ becomes pending; reset during stall+redirect clears everything.
    step(1,0,3'b000,0,32'h0,1,        32'h80000008, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h8000000C, 32'h0,        32'h8000000C, 1,1);
    step(0,1,3'b011,0,32'h00001234,0, 32'h80000000, 32'h0,        32'h0,        0,0);
    step(1,0,3'b100,0,32'h0,0,        32'h80000004, 32'h24080001, 32'h80000004, 1,0);
    // Undefined select code with branch_taken: no redirect.
    step(1,0,3'b101,1,32'h0,0,        32'h80000008, 32'h24090002, 32'h80000008, 1,0);
    @(negedge clk);
    pcsrc = 3'b100; branch_taken = 1'b0; irq = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
